spi_slave_rx_tx: RTL

- Bit-serial SPI slave: the peer that sits on the far end of spi_master's MOSI/MISO/spi_sclk/spi_cs wires.
- Oversamples the SPI pins in the system clock domain and deserialises 16-bit MOSI frames into a parallel word with a valid pulse.
- Simultaneously serialises a preloaded 16-bit response word onto MISO.
- Mode 0 (sample on sclk rise, shift on sclk fall), chip-select active-low, LSB-first by default.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_pin_sync.sv | 32 +++
 rtl/spi_slave_rx_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width, bit counter width and the FSM state encoding.
package spi_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE,
      WAIT_CS
   } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for one asynchronous SPI pin: STAGES-deep flop chain plus a previous-value flop,
// giving the synchronised level and single-cycle rise/fall events.
module spi_pin_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], pin};
         prev  <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = chain[STAGES-1] & ~prev;
   assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// Mode-0 SPI slave: oversampled pins, DATA_W-bit receive with valid pulse and simultaneous response transmit.
// Bit order is LSB-first unless SPI_SLAVE_MSB_FIRST_EN is defined.
module spi_slave_rx_tx
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs,
   input  logic              spi_sclk,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_busy,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              frame_err
);

   if (DATA_W > 31 || DATA_W < 2) begin : g_bad_data_w
      $error("spi_slave_rx_tx: DATA_W must be in 2..31");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("spi_slave_rx_tx: SYNC_STAGES must be at least 2");
   end

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

   logic cs_level, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi_cs),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi_sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk   (clk),
      .rst   (rst),
      .pin   (mosi),
      .level (mosi_level),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   spi_state_t        state;
   logic [DATA_W-1:0] tx_buf;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_next;
   logic              tx_first;
   logic [CNT_W-1:0]  cnt_next;
   logic              final_rise;
   logic              unused_bits;

   // Shift direction and the MISO tap point are the only things the bit order changes.
`ifdef SPI_SLAVE_MSB_FIRST_EN
   assign rx_next     = {rx_shift[DATA_W-2:0], mosi_level};
   assign tx_next     = {tx_shift[DATA_W-2:0], 1'b0};
   assign tx_first    = tx_buf[DATA_W-1];
   assign unused_bits = ^{tx_shift[DATA_W-1], sclk_level, mosi_rise, mosi_fall};
`else
   assign rx_next     = {mosi_level, rx_shift[DATA_W-1:1]};
   assign tx_next     = {1'b0, tx_shift[DATA_W-1:1]};
   assign tx_first    = tx_buf[0];
   assign unused_bits = ^{tx_shift[0], sclk_level, mosi_rise, mosi_fall};
`endif

   assign cnt_next   = bit_cnt + CNT_W'(1);
   assign final_rise = sclk_rise && (cnt_next == FULL_CNT);

   // A final sclk rise wins over a coincident cs rise, so WAIT_CS leaves on the cs level
   // rather than on the (already consumed) rise event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         tx_buf    <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         bit_cnt   <= '0;
         miso      <= 1'b0;
         tx_busy   <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (tx_load) begin
            tx_buf <= tx_data;
         end
         case (state)
            IDLE: begin
               miso    <= 1'b0;
               tx_busy <= 1'b0;
               if (cs_fall) begin
                  tx_shift <= tx_buf;
                  bit_cnt  <= '0;
                  miso     <= tx_first;
                  tx_busy  <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               tx_busy <= 1'b1;
               if (final_rise) begin
                  rx_shift <= rx_next;
                  bit_cnt  <= cnt_next;
                  state    <= DONE;
               end else if (cs_rise) begin
                  frame_err <= 1'b1;
                  rx_shift  <= '0;
                  bit_cnt   <= '0;
                  miso      <= 1'b0;
                  tx_busy   <= 1'b0;
                  state     <= IDLE;
               end else if (sclk_rise) begin
                  rx_shift <= rx_next;
                  bit_cnt  <= cnt_next;
               end else if (sclk_fall && bit_cnt < FULL_CNT) begin
                  tx_shift <= tx_next;
`ifdef SPI_SLAVE_MSB_FIRST_EN
                  miso     <= tx_next[DATA_W-1];
`else
                  miso     <= tx_next[0];
`endif
               end
            end
            DONE: begin
               rx_data  <= rx_shift;
               rx_valid <= 1'b1;
               bit_cnt  <= FULL_CNT;
               miso     <= 1'b0;
               state    <= WAIT_CS;
            end
            WAIT_CS: begin
               miso    <= 1'b0;
               tx_busy <= 1'b0;
               if (cs_level) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
